// File: rtl/prog_delay_timer.sv
`default_nettype none
// ============================================================================
//  Module   : prog_delay_timer
//  Brief    : Runtime-programmable delay/interval timer with one-shot,
//             retriggerable one-shot and periodic modes, pause and readback.
//             Optional prescaler enabled by defining DELAY_PRESCALE_EN.
//  Revision : 1.0  initial release
// ============================================================================
module prog_delay_timer #(
   parameter int WIDTH    = 16,
   parameter int PRESCALE = 1
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iStart,
   input  logic             iStop,
   input  logic             iPause,
   input  logic [1:0]       iMode,
   input  logic [WIDTH-1:0] iLoad,
   output logic             oBusy,
   output logic             oDone,
   output logic             oPulse,
   output logic [WIDTH-1:0] oCount
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] cModeOne   = 2'b00;
   localparam logic [1:0] cModeRetrg = 2'b01;
   localparam logic [1:0] cModePer   = 2'b10;

   state_t           rState;
   logic [WIDTH-1:0] rTarget;
   logic [1:0]       rMode;

   logic             wStartOk;
   logic             wTick;
   logic             wTerminal;
   logic [WIDTH-1:0] wLoadN;
   logic [1:0]       wModeN;

   // Plain one-shot ignores a start while running; other modes restart.
   assign wStartOk  = iStart && ((rState != RUN) || (rMode != cModeOne));
   assign wLoadN    = (iLoad == '0) ? WIDTH'(1) : iLoad;
   assign wModeN    = (iMode == 2'b11) ? cModeOne : iMode;
   assign wTerminal = (oCount == (rTarget - WIDTH'(1)));

`ifdef DELAY_PRESCALE_EN
   localparam int cPreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [cPreW-1:0] cPreMax = cPreW'(PRESCALE - 1);

   logic [cPreW-1:0] rPre;

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         rPre <= '0;
      end else if (iStop || wStartOk || (rState != RUN)) begin
         rPre <= '0;
      end else if (!iPause) begin
         rPre <= wTick ? '0 : rPre + cPreW'(1);
      end
   end

   assign wTick = (rPre == cPreMax);
`else
   localparam int unusedPrescale = PRESCALE;

   assign wTick = 1'b1;
`endif

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         rState  <= IDLE;
         rTarget <= '0;
         rMode   <= cModeOne;
         oBusy   <= 1'b0;
         oDone   <= 1'b0;
         oPulse  <= 1'b0;
         oCount  <= '0;
      end else begin
         oPulse <= 1'b0;
         if (iStop) begin
            rState <= IDLE;
            oCount <= '0;
            oBusy  <= 1'b0;
            oDone  <= 1'b0;
         end else if (wStartOk) begin
            rState  <= RUN;
            rTarget <= wLoadN;
            rMode   <= wModeN;
            oCount  <= '0;
            oBusy   <= 1'b1;
            oDone   <= 1'b0;
         end else begin
            case (rState)
               IDLE: begin
                  oCount <= '0;
                  oBusy  <= 1'b0;
                  oDone  <= 1'b0;
               end
               RUN: begin
                  if (!iPause && wTick) begin
                     if (wTerminal) begin
                        oPulse <= 1'b1;
                        if (rMode == cModePer) begin
                           oCount <= '0;
                        end else begin
                           rState <= DONE;
                           oBusy  <= 1'b0;
                           oDone  <= 1'b1;
                        end
                     end else begin
                        oCount <= oCount + WIDTH'(1);
                     end
                  end
               end
               DONE: begin
                  oBusy <= 1'b0;
                  oDone <= 1'b1;
               end
               default: begin
                  rState <= IDLE;
                  oCount <= '0;
                  oBusy  <= 1'b0;
                  oDone  <= 1'b0;
               end
            endcase
         end
      end
   end

   // Retrigger mode is distinguished only by being "not plain one-shot".
   logic unusedModeRetrg;
   assign unusedModeRetrg = (rMode == cModeRetrg);

endmodule
`default_nettype wire

// File: tb/tb_prog_delay_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_delay_timer
//  Brief    : Self-checking bench for prog_delay_timer against an
//             elapsed-cycle reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prog_delay_timer;

`ifdef DELAY_PRESCALE_EN
   localparam int cP = 3;
`else
   localparam int cP = 1;
`endif

   logic        iClk;
   logic        iRst;
   logic        iStart;
   logic        iStop;
   logic        iPause;
   logic [1:0]  iMode;
   logic [15:0] iLoad;
   logic        oBusy;
   logic        oDone;
   logic        oPulse;
   logic [15:0] oCount;

   int total = 0;
   int bad   = 0;

   // Reference model: active cycles elapsed since start
   bit mRun, mDone, mPulse;
   int mMode, mN, mEl;

   prog_delay_timer #(.WIDTH(16), .PRESCALE(cP)) dut (
      .iClk(iClk), .iRst(iRst), .iStart(iStart), .iStop(iStop),
      .iPause(iPause), .iMode(iMode), .iLoad(iLoad),
      .oBusy(oBusy), .oDone(oDone), .oPulse(oPulse), .oCount(oCount)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int expCount();
      if (mRun) return (mMode == 2) ? (mEl / cP) % mN : mEl / cP;
      if (mDone) return mN - 1;
      return 0;
   endfunction

   task automatic modelReset();
      mRun = 0; mDone = 0; mPulse = 0; mMode = 0; mN = 1; mEl = 0;
   endtask

   task automatic modelEdge();
      mPulse = 0;
      if (iStop) begin
         mRun = 0; mDone = 0; mEl = 0;
      end else if (iStart && (!mRun || mMode != 0)) begin
         mRun  = 1; mDone = 0; mEl = 0;
         mMode = (iMode == 2'b11) ? 0 : int'(iMode);
         mN    = (iLoad == 16'd0) ? 1 : int'(iLoad);
      end else if (mRun && !iPause) begin
         mEl++;
         if (mMode == 2) begin
            if (mEl % (mN * cP) == 0) mPulse = 1;
         end else if (mEl == mN * cP) begin
            mPulse = 1; mRun = 0; mDone = 1;
         end
      end
   endtask

   task automatic checkAll(input string tag);
      chk({tag, ".busy"},  32'(oBusy),  32'(mRun));
      chk({tag, ".done"},  32'(oDone),  32'(mDone));
      chk({tag, ".pulse"}, 32'(oPulse), 32'(mPulse));
      chk({tag, ".count"}, 32'(oCount), 32'(expCount()));
   endtask

   task automatic cyc(input logic s, input logic p, input logic q,
                      input logic [1:0] m, input logic [15:0] l, input string tag);
      iStart = s; iStop = p; iPause = q; iMode = m; iLoad = l;
      @(posedge iClk);
      modelEdge();
      #1;
      checkAll(tag);
   endtask

   task automatic idle(input string tag);
      cyc(1'b0, 1'b0, 1'b0, 2'b00, 16'd0, tag);
   endtask

   initial begin
      int firstPulse;
      int nPulse;

      iRst = 1'b0; iStart = 1'b0; iStop = 1'b0; iPause = 1'b0;
      iMode = 2'b00; iLoad = 16'd0;
      modelReset();
      #12;
      checkAll("reset");
      iRst = 1'b1;

      // One-shot, N=5
      cyc(1'b1, 1'b0, 1'b0, 2'b00, 16'd5, "os5_start");
      firstPulse = -1;
      for (int e = 1; e <= 5 * cP + 3; e++) begin
         idle("os5");
         if (oPulse && firstPulse < 0) firstPulse = e;
      end
      chk("os5_pulse_edge", 32'(firstPulse), 32'(5 * cP));
      chk("os5_done_hold", 32'(oDone), 32'd1);
      chk("os5_count", 32'(oCount), 32'd4);

      // iLoad=0 behaves as N=1
      cyc(1'b1, 1'b0, 1'b0, 2'b00, 16'd0, "n0_start");
      firstPulse = -1;
      for (int e = 1; e <= cP + 2; e++) begin
         idle("n0");
         if (oPulse && firstPulse < 0) firstPulse = e;
      end
      chk("n0_pulse_edge", 32'(firstPulse), 32'(cP));

      // Periodic N=3, stop sampled at edge 7
      cyc(1'b1, 1'b0, 1'b0, 2'b10, 16'd3, "per_start");
      firstPulse = -1; nPulse = 0;
      for (int e = 1; e <= 10 * cP; e++) begin
         cyc(1'b0, (e == 7 * cP), 1'b0, 2'b00, 16'd0, "per");
         if (oPulse) begin
            nPulse++;
            if (firstPulse < 0) firstPulse = e;
         end
      end
      chk("per_first_edge", 32'(firstPulse), 32'(3 * cP));
      chk("per_pulse_cnt", 32'(nPulse), 32'd2);

      // Retrigger mode 01: restart at edge 2 with N=6
      cyc(1'b1, 1'b0, 1'b0, 2'b01, 16'd4, "rt_start");
      firstPulse = -1;
      for (int e = 1; e <= 2 + 6 * cP + 2; e++) begin
         cyc((e == 2), 1'b0, 1'b0, 2'b01, (e == 2) ? 16'd6 : 16'd4, "rt");
         if (oPulse && firstPulse < 0) firstPulse = e;
      end
      chk("rt_pulse_edge", 32'(firstPulse), 32'(2 + 6 * cP));

      // Same in mode 00: second start ignored
      cyc(1'b0, 1'b1, 1'b0, 2'b00, 16'd0, "os_clr");
      cyc(1'b1, 1'b0, 1'b0, 2'b00, 16'd4, "osr_start");
      firstPulse = -1;
      for (int e = 1; e <= 4 * cP + 6; e++) begin
         cyc((e == 2), 1'b0, 1'b0, 2'b00, (e == 2) ? 16'd6 : 16'd4, "osr");
         if (oPulse && firstPulse < 0) firstPulse = e;
      end
      chk("osr_pulse_edge", 32'(firstPulse), 32'(4 * cP));

      // Pause for edges 2-4
      cyc(1'b1, 1'b0, 1'b0, 2'b00, 16'd4, "pz_start");
      firstPulse = -1;
      for (int e = 1; e <= 4 * cP + 6; e++) begin
         cyc(1'b0, 1'b0, (e >= 2 && e <= 4), 2'b00, 16'd0, "pz");
         if (oPulse && firstPulse < 0) firstPulse = e;
      end
      chk("pz_pulse_edge", 32'(firstPulse), 32'(4 * cP + 3));

      // Stop and start together -> IDLE
      cyc(1'b1, 1'b1, 1'b0, 2'b10, 16'd3, "stopstart");
      chk("stopstart_busy", 32'(oBusy), 32'd0);

      // Asynchronous reset mid-run
      cyc(1'b1, 1'b0, 1'b0, 2'b00, 16'd10, "ar_start");
      idle("ar"); idle("ar");
      #2 iRst = 1'b0;
      #1;
      modelReset();
      checkAll("async_rst");
      #3 iRst = 1'b1;

      // Maximum load, no wrap
      cyc(1'b1, 1'b0, 1'b0, 2'b00, 16'hFFFF, "max_start");
      firstPulse = -1;
      for (int e = 1; e <= 65535 * cP + 2; e++) begin
         iStart = 1'b0; iStop = 1'b0; iPause = 1'b0;
         @(posedge iClk);
         modelEdge();
         #1;
         if (oPulse && firstPulse < 0) firstPulse = e;
      end
      chk("max_pulse_edge", 32'(firstPulse), 32'(65535 * cP));
      checkAll("max_end");

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic       s, p, q;
         logic [1:0] m;
         logic [15:0] l;
         s = ($urandom_range(0, 7) == 0);
         p = ($urandom_range(0, 29) == 0);
         q = ($urandom_range(0, 4) == 0);
         m = 2'($urandom_range(0, 3));
         l = 16'($urandom_range(0, 12));
         cyc(s, p, q, m, l, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/prog_delay_timer.md
Name: prog_delay_timer

Overview:
Runtime-programmable delay/interval timer, the parametrised successor of the fixed-COUNT delay block.
- Delay length is loaded per run from a port instead of a compile-time parameter.
- Supports one-shot, retriggerable one-shot and periodic modes, pause/hold, and a count readback.
- Used by sequencers and power/reset controllers that need several different delays from one instance.

Parameters:
WIDTH, 16, width of load value and counter; max delay 2^WIDTH-1 ticks
PRESCALE, 1, clock cycles per count tick; used only when DELAY_PRESCALE_EN is defined; legal range >=1

Ports:
iClk  input  1  clock
iRst  input  1  asynchronous active-low reset
iStart  input  1  single-cycle start/retrigger request
iStop  input  1  abort; forces IDLE
iPause  input  1  level; holds count while high
iMode  input  2  00 one-shot, 01 retriggerable one-shot, 10 periodic, 11 treated as 00
iLoad  input  WIDTH  delay length N in ticks; sampled with iStart
oBusy  output  1  high while state is RUN
oDone  output  1  level; high in DONE state (one-shot modes only)
oPulse  output  1  one-cycle strobe at each terminal count
oCount  output  WIDTH  current tick count

Behaviour:
- Reset (iRst low, async): state IDLE, internal count 0, latched target 0, latched mode 00, oBusy 0, oDone 0, oPulse 0, oCount 0. All outputs are registered.
- States:
  - IDLE: counter cleared.
  - RUN: counting.
  - DONE: terminal count reached in a one-shot mode.
- Priority each cycle: iStop > iStart > iPause.
- iStop in any state:
  - Next state IDLE; count 0; oDone 0; oPulse 0.
  - A pulse due the same cycle is suppressed.
- iStart in IDLE or DONE:
  - Latch target N = iLoad (iLoad==0 is treated as 1) and latch iMode.
  - Count <= 0; next state RUN; oDone <= 0.
- iStart in RUN:
  - Latched mode 01 or 10: restart exactly as from IDLE, with the new iLoad/iMode; this overrides a terminal event in the same cycle.
  - Latched mode 00: ignored.
- RUN, per tick, not paused:
  - If count == N-1: terminal event, oPulse <= 1 for one cycle.
  - Modes 00/01: next state DONE, oDone <= 1, count holds at N-1.
  - Mode 10: count <= 0, stay RUN (repeats every N ticks).
  - Otherwise count <= count + 1.
- Latency: with tick = every cycle, oDone/oPulse rise exactly N clock edges after the edge that samples iStart. N=1 gives assertion on the next edge.
- Pause:
  - iPause high in RUN freezes count, prescaler and terminal detection.
  - No effect in IDLE or DONE.
  - Resuming continues from the held count; total delay = N + paused cycles.
- Signals in DONE:
  - oDone stays high until iStop or iStart.
  - oBusy is 0.
  - oPulse is never repeated.
- Count arithmetic is unsigned WIDTH bits and never wraps: terminal detection stops it at N-1 <= 2^WIDTH-2.
- Reset asserted mid-run aborts immediately with no pulse.

Optional Feature:
Macro DELAY_PRESCALE_EN.
- Defined:
  - A clog2(PRESCALE)-bit prescaler generates a tick every PRESCALE cycles while in RUN and not paused.
  - The prescaler is cleared on start, restart and stop.
  - Delay = N*PRESCALE cycles from the start edge.
  - PRESCALE=1 is cycle-identical to the macro-undefined build.
- Undefined: no prescaler logic; tick every cycle; PRESCALE is ignored.

Test Plan:
- Reset, then iStart with iLoad=5, iMode=00 -> oBusy high edges 1-5; oPulse and oDone rise at edge 5; oDone stays high; oCount=4.
- iLoad=0 start -> behaves as N=1: oPulse/oDone at edge 1. iLoad=2^WIDTH-1 -> done after 65535 cycles with no wrap.
- Mode 10, iLoad=3, run 10 cycles -> oPulse at edges 3, 6, 9; oDone never set; iStop at edge 7 -> IDLE, no pulse at edge 9.
- Mode 01, iLoad=4; re-iStart with iLoad=6 at edge 2 -> pulse at edge 8. Same sequence in mode 00 -> second start ignored, pulse at edge 4.
- Mode 00, iLoad=4; iPause high for edges 2-4 -> pulse at edge 7. iStop and iStart in the same cycle -> IDLE. iRst low mid-run -> all outputs 0 asynchronously.
- DELAY_PRESCALE_EN with PRESCALE=3, iLoad=4 -> oPulse at edge 12.
